// File: rtl/ccip_rd_requester.sv
// CCI-P channel-0 read engine: issues N cache-line reads from a base address and forwards the returned lines tagged with their index.
// Optional response watchdog is compiled in with `define CCIP_RD_WATCHDOG_EN.
module ccip_rd_requester #(
    parameter int MAX_OUT   = 32,
    parameter int WD_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [41:0]  base_addr,
    input  logic [15:0]  num_lines,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         req_valid,
    output logic [41:0]  req_addr,
    output logic [15:0]  req_mdata,
    input  logic         req_almfull,
    input  logic         rsp_valid,
    input  logic [15:0]  rsp_mdata,
    input  logic [511:0] rsp_data,
    output logic         out_valid,
    output logic [15:0]  out_idx,
    output logic [511:0] out_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    localparam logic [15:0] MAX_OUT_W = 16'(MAX_OUT);

    state_t      state;
    logic [41:0] base_q;
    logic [15:0] num_q;
    logic [15:0] issued;
    logic [15:0] received;
    logic [15:0] outstanding;

    logic        start_acc;
    logic        rsp_ok;
    logic        rsp_bad;
    logic        issue_ok;
    logic        wd_hit;
    logic [15:0] received_nxt;

    assign start_acc    = start && !busy;
    assign rsp_ok       = rsp_valid && busy && (rsp_mdata < num_q);
    assign rsp_bad      = rsp_valid && !rsp_ok;
    assign issue_ok     = (state == ISSUE) && !req_almfull &&
                          (outstanding < MAX_OUT_W) && (issued < num_q);
    assign received_nxt = received + 16'(rsp_ok);

`ifdef CCIP_RD_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // Cycles since the last sign of life from the host while reads are in flight.
    assign wd_hit = ((state == ISSUE) || (state == DRAIN)) && !rsp_ok &&
                    (outstanding != 16'd0) && (wd_cnt == WD_W'(WD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (start_acc || rsp_ok || wd_hit || (outstanding == 16'd0)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_hit = (WD_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base_q      <= '0;
            num_q       <= '0;
            issued      <= '0;
            received    <= '0;
            outstanding <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            req_valid   <= 1'b0;
            req_addr    <= '0;
            req_mdata   <= '0;
            out_valid   <= 1'b0;
            out_idx     <= '0;
            out_data    <= '0;
        end else begin
            done      <= 1'b0;
            req_valid <= issue_ok;
            out_valid <= rsp_ok;

            if (issue_ok) begin
                req_addr  <= base_q + 42'(issued);
                req_mdata <= issued;
            end

            // Forwarding path: dropped responses leave the last good line in place.
            if (rsp_ok) begin
                out_idx  <= rsp_mdata;
                out_data <= rsp_data;
            end

            if (rsp_bad || wd_hit) begin
                err <= 1'b1;
            end else if (start_acc) begin
                err <= 1'b0;
            end

            if (start_acc || wd_hit) begin
                issued      <= '0;
                received    <= '0;
                outstanding <= '0;
            end else begin
                if (issue_ok) begin
                    issued <= issued + 16'd1;
                end
                if (rsp_ok) begin
                    received <= received_nxt;
                end
                if (issue_ok && !rsp_ok) begin
                    outstanding <= outstanding + 16'd1;
                end else if (!issue_ok && rsp_ok && (outstanding != 16'd0)) begin
                    outstanding <= outstanding - 16'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (start_acc) begin
                        base_q <= base_addr;
                        num_q  <= num_lines;
                        busy   <= 1'b1;
                        state  <= (num_lines == 16'd0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (wd_hit) begin
                        state <= FINISH;
                    end else if (issued == num_q) begin
                        state <= (received_nxt == num_q) ? FINISH : DRAIN;
                    end
                end
                DRAIN: begin
                    if (wd_hit || (received_nxt == num_q)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccip_rd_requester.sv
// Directed self-checking bench for ccip_rd_requester: two instances (MAX_OUT 32 and 2) share the host-side inputs.
module tb_ccip_rd_requester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, start_b, req_almfull, rsp_valid;
    logic [41:0]  base_addr;
    logic [15:0]  num_lines, rsp_mdata;
    logic [511:0] rsp_data;

    logic         busy, done, err, req_valid, out_valid;
    logic [41:0]  req_addr;
    logic [15:0]  req_mdata, out_idx;
    logic [511:0] out_data;

    logic         busy_b, done_b, err_b, req_valid_b, out_valid_b;
    logic [41:0]  req_addr_b;
    logic [15:0]  req_mdata_b, out_idx_b;
    logic [511:0] out_data_b;

    ccip_rd_requester #(.MAX_OUT(32), .WD_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_lines(num_lines),
        .busy(busy), .done(done), .err(err),
        .req_valid(req_valid), .req_addr(req_addr), .req_mdata(req_mdata), .req_almfull(req_almfull),
        .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
    );

    ccip_rd_requester #(.MAX_OUT(2), .WD_CYCLES(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_addr), .num_lines(num_lines),
        .busy(busy_b), .done(done_b), .err(err_b),
        .req_valid(req_valid_b), .req_addr(req_addr_b), .req_mdata(req_mdata_b), .req_almfull(req_almfull),
        .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
        .out_valid(out_valid_b), .out_idx(out_idx_b), .out_data(out_data_b)
    );

    typedef struct { int cyc; logic [41:0] addr; logic [15:0] mdata; } req_t;
    typedef struct { int cyc; logic [15:0] idx; logic [511:0] data; } out_t;
    typedef struct { int due; logic [15:0] tag; } pend_t;

    req_t  req_q_a[$], req_q_b[$];
    out_t  out_q_a[$], out_q_b[$];
    int    done_q_a[$], done_q_b[$];
    pend_t pend_q[$];

    int cyc = 0;
    int cmp = 0;
    int nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled mid-cycle.
    always @(negedge clk) begin
        if (req_valid)   req_q_a.push_back('{cyc, req_addr, req_mdata});
        if (req_valid_b) req_q_b.push_back('{cyc, req_addr_b, req_mdata_b});
        if (out_valid)   out_q_a.push_back('{cyc, out_idx, out_data});
        if (out_valid_b) out_q_b.push_back('{cyc, out_idx_b, out_data_b});
        if (done)        done_q_a.push_back(cyc);
        if (done_b)      done_q_b.push_back(cyc);
    end

    function automatic logic [511:0] mkdata(input logic [15:0] t);
        return {16{16'hD00D, t}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_q_a.delete(); req_q_b.delete(); out_q_a.delete(); out_q_b.delete();
        done_q_a.delete(); done_q_b.delete(); pend_q.delete();
    endtask

    task automatic drive_rsp(input logic [15:0] tag);
        rsp_valid = 1'b1;
        rsp_mdata = tag;
        rsp_data  = mkdata(tag);
    endtask

    // Host model: answers each request in order, `delay` cycles after it is seen.
    task automatic host_cycle(input bit use_b, input int delay);
        pend_t p;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            drive_rsp(pend_q[0].tag);
            void'(pend_q.pop_front());
        end else begin
            rsp_valid = 1'b0;
        end
        if (use_b ? req_valid_b : req_valid) begin
            p.due = cyc + delay;
            p.tag = use_b ? req_mdata_b : req_mdata;
            pend_q.push_back(p);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        cmp++; if ({busy, done, err, req_valid, out_valid} !== 5'b0) begin nfail++;
            $display("FAIL reset_flags: got %b want 00000", {busy, done, err, req_valid, out_valid}); end
        cmp++; if (req_addr !== 42'h0) begin nfail++; $display("FAIL reset_req_addr: got %h want 0", req_addr); end
        cmp++; if (req_mdata !== 16'h0) begin nfail++; $display("FAIL reset_req_mdata: got %h want 0", req_mdata); end
        cmp++; if (out_idx !== 16'h0) begin nfail++; $display("FAIL reset_out_idx: got %h want 0", out_idx); end
        cmp++; if (out_data !== 512'h0) begin nfail++; $display("FAIL reset_out_data: got nonzero want 0"); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int s;
        clear_logs();
        base_addr = 42'h100; num_lines = 16'd4;
        start = 1'b1; s = cyc; step(); start = 1'b0;
        cmp++; if (busy !== 1'b1) begin nfail++; $display("FAIL basic_busy: got %b want 1", busy); end
        repeat (20) host_cycle(1'b0, 5);
        cmp++; if (req_q_a.size() != 4) begin nfail++; $display("FAIL basic_nreq: got %0d want 4", req_q_a.size()); end
        for (int i = 0; i < 4; i++) begin
            cmp++;
            if (req_q_a[i].addr !== 42'h100 + i || req_q_a[i].mdata !== 16'(i) || req_q_a[i].cyc != s + 2 + i) begin
                nfail++;
                $display("FAIL basic_req%0d: got addr=%h mdata=%0d cyc=%0d want addr=%h mdata=%0d cyc=%0d",
                         i, req_q_a[i].addr, req_q_a[i].mdata, req_q_a[i].cyc, 42'h100 + i, i, s + 2 + i);
            end
        end
        cmp++; if (out_q_a.size() != 4) begin nfail++; $display("FAIL basic_nout: got %0d want 4", out_q_a.size()); end
        for (int i = 0; i < 4; i++) begin
            cmp++;
            if (out_q_a[i].idx !== 16'(i) || out_q_a[i].data !== mkdata(16'(i)) || out_q_a[i].cyc != s + 8 + i) begin
                nfail++;
                $display("FAIL basic_out%0d: got idx=%0d cyc=%0d want idx=%0d cyc=%0d",
                         i, out_q_a[i].idx, out_q_a[i].cyc, i, s + 8 + i);
            end
        end
        cmp++; if (done_q_a.size() != 1 || done_q_a[0] != s + 12) begin nfail++;
            $display("FAIL basic_done: got n=%0d cyc=%0d want n=1 cyc=%0d", done_q_a.size(), done_q_a[0], s + 12); end
        cmp++; if (err !== 1'b0) begin nfail++; $display("FAIL basic_err: got %b want 0", err); end
    endtask

    task automatic test_out_of_order();
        int ord [8] = '{7, 0, 5, 1, 6, 2, 4, 3};
        int r0;
        clear_logs();
        base_addr = 42'h500; num_lines = 16'd8;
        start = 1'b1; step(); start = 1'b0;
        repeat (10) step();
        r0 = cyc;
        for (int i = 0; i < 8; i++) begin
            drive_rsp(16'(ord[i]));
            step();
        end
        rsp_valid = 1'b0;
        repeat (5) step();
        cmp++; if (req_q_a.size() != 8) begin nfail++; $display("FAIL ooo_nreq: got %0d want 8", req_q_a.size()); end
        cmp++; if (out_q_a.size() != 8) begin nfail++; $display("FAIL ooo_nout: got %0d want 8", out_q_a.size()); end
        for (int i = 0; i < 8; i++) begin
            cmp++;
            if (out_q_a[i].idx !== 16'(ord[i]) || out_q_a[i].data !== mkdata(16'(ord[i])) || out_q_a[i].cyc != r0 + 1 + i) begin
                nfail++;
                $display("FAIL ooo_out%0d: got idx=%0d cyc=%0d want idx=%0d cyc=%0d",
                         i, out_q_a[i].idx, out_q_a[i].cyc, ord[i], r0 + 1 + i);
            end
        end
        cmp++; if (done_q_a.size() != 1 || done_q_a[0] != r0 + 9) begin nfail++;
            $display("FAIL ooo_done: got n=%0d cyc=%0d want n=1 cyc=%0d", done_q_a.size(), done_q_a[0], r0 + 9); end
        cmp++; if (err !== 1'b0) begin nfail++; $display("FAIL ooo_err: got %b want 0", err); end
    endtask

    task automatic test_backpressure();
        int c0;
        clear_logs();
        base_addr = 42'h2000; num_lines = 16'd6;
        start_b = 1'b1; step(); start_b = 1'b0;
        repeat (20) step();
        cmp++; if (req_q_b.size() != 2) begin nfail++; $display("FAIL bp_cap: got %0d reqs want 2", req_q_b.size()); end
        c0 = cyc;
        req_almfull = 1'b1;
        drive_rsp(16'd0); step();
        drive_rsp(16'd1); step();
        rsp_valid = 1'b0;
        repeat (6) step();
        req_almfull = 1'b0;
        step();
        cmp++; if (req_q_b.size() != 2) begin nfail++; $display("FAIL bp_almfull: got %0d reqs want 2", req_q_b.size()); end
        repeat (30) host_cycle(1'b1, 3);
        cmp++; if (req_q_b.size() != 6) begin nfail++; $display("FAIL bp_nreq: got %0d want 6", req_q_b.size()); end
        cmp++; if (req_q_b[2].cyc != c0 + 9) begin nfail++;
            $display("FAIL bp_resume: got cyc=%0d want cyc=%0d", req_q_b[2].cyc, c0 + 9); end
        for (int i = 0; i < 6; i++) begin
            cmp++;
            if (req_q_b[i].addr !== 42'h2000 + i || req_q_b[i].mdata !== 16'(i)) begin
                nfail++;
                $display("FAIL bp_req%0d: got addr=%h mdata=%0d want addr=%h mdata=%0d",
                         i, req_q_b[i].addr, req_q_b[i].mdata, 42'h2000 + i, i);
            end
        end
        cmp++; if (out_q_b.size() != 6) begin nfail++; $display("FAIL bp_nout: got %0d want 6", out_q_b.size()); end
        for (int i = 0; i < 6; i++) begin
            cmp++;
            if (out_q_b[i].data !== mkdata(out_q_b[i].idx) || out_q_b[i].idx > 16'd5) begin
                nfail++; $display("FAIL bp_out%0d: got idx=%0d with data not matching tag", i, out_q_b[i].idx);
            end
        end
        cmp++; if (done_q_b.size() != 1 || err_b !== 1'b0) begin nfail++;
            $display("FAIL bp_done: got n=%0d err=%b want n=1 err=0", done_q_b.size(), err_b); end
    endtask

    task automatic test_wrap();
        clear_logs();
        base_addr = 42'h3FF_FFFF_FFFF; num_lines = 16'd2;
        start = 1'b1; step(); start = 1'b0;
        repeat (15) host_cycle(1'b0, 3);
        cmp++; if (req_q_a.size() != 2) begin nfail++; $display("FAIL wrap_nreq: got %0d want 2", req_q_a.size()); end
        cmp++; if (req_q_a[0].addr !== 42'h3FF_FFFF_FFFF || req_q_a[0].mdata !== 16'd0) begin nfail++;
            $display("FAIL wrap_req0: got addr=%h mdata=%0d want addr=3ffffffffff mdata=0", req_q_a[0].addr, req_q_a[0].mdata); end
        cmp++; if (req_q_a[1].addr !== 42'h0 || req_q_a[1].mdata !== 16'd1) begin nfail++;
            $display("FAIL wrap_req1: got addr=%h mdata=%0d want addr=0 mdata=1", req_q_a[1].addr, req_q_a[1].mdata); end
        cmp++; if (done_q_a.size() != 1 || err !== 1'b0) begin nfail++;
            $display("FAIL wrap_done: got n=%0d err=%b want n=1 err=0", done_q_a.size(), err); end
    endtask

    task automatic test_zero_lines();
        int s;
        clear_logs();
        num_lines = 16'd0;
        start = 1'b1; s = cyc; step(); start = 1'b0;
        cmp++; if (busy !== 1'b1 || done !== 1'b0) begin nfail++;
            $display("FAIL zero_t1: got busy=%b done=%b want busy=1 done=0", busy, done); end
        step();
        cmp++; if (busy !== 1'b0 || done !== 1'b1) begin nfail++;
            $display("FAIL zero_t2: got busy=%b done=%b want busy=0 done=1", busy, done); end
        repeat (3) step();
        cmp++; if (req_q_a.size() != 0 || done_q_a.size() != 1 || done_q_a[0] != s + 2) begin nfail++;
            $display("FAIL zero_log: got nreq=%0d ndone=%0d want nreq=0 ndone=1", req_q_a.size(), done_q_a.size()); end
    endtask

    task automatic test_errors();
        int s;
        clear_logs();
        base_addr = 42'h40; num_lines = 16'd4;
        start = 1'b1; s = cyc; step(); start = 1'b0;
        repeat (6) step();
        drive_rsp(16'd9); step(); rsp_valid = 1'b0;
        cmp++; if (err !== 1'b1 || out_valid !== 1'b0) begin nfail++;
            $display("FAIL err_badtag: got err=%b out_valid=%b want err=1 out_valid=0", err, out_valid); end
        for (int i = 0; i < 4; i++) begin
            drive_rsp(16'(i)); step();
        end
        rsp_valid = 1'b0;
        repeat (4) step();
        cmp++; if (out_q_a.size() != 4 || done_q_a.size() != 1 || done_q_a[0] != s + 13) begin nfail++;
            $display("FAIL err_job: got nout=%0d ndone=%0d want nout=4 ndone=1 at cyc %0d", out_q_a.size(), done_q_a.size(), s + 13); end
        cmp++; if (err !== 1'b1) begin nfail++; $display("FAIL err_sticky: got %b want 1", err); end
        num_lines = 16'd0;
        start = 1'b1; step(); start = 1'b0;
        cmp++; if (err !== 1'b0) begin nfail++; $display("FAIL err_clear: got %b want 0", err); end
        repeat (2) step();
        drive_rsp(16'd0); step(); rsp_valid = 1'b0;
        cmp++; if (err !== 1'b1 || out_valid !== 1'b0) begin nfail++;
            $display("FAIL err_idle: got err=%b out_valid=%b want err=1 out_valid=0", err, out_valid); end
        cmp++; if (out_q_a.size() != 4) begin nfail++; $display("FAIL err_idle_fwd: got nout=%0d want 4", out_q_a.size()); end
    endtask

    task automatic test_reset_midjob();
        base_addr = 42'h800; num_lines = 16'd8;
        start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
        drive_rsp(16'd0); step(); rsp_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        cmp++; if ({busy, done, err, req_valid, out_valid} !== 5'b0) begin nfail++;
            $display("FAIL rst_mid_flags: got %b want 00000", {busy, done, err, req_valid, out_valid}); end
        cmp++; if (req_addr !== 42'h0 || req_mdata !== 16'h0 || out_idx !== 16'h0 || out_data !== 512'h0) begin nfail++;
            $display("FAIL rst_mid_data: got addr=%h mdata=%h idx=%h want all 0", req_addr, req_mdata, out_idx); end
        step(); step();
        rst_n = 1'b1;
        step();
        drive_rsp(16'd0); step(); rsp_valid = 1'b0;
        cmp++; if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin nfail++;
            $display("FAIL rst_post_rsp: got err=%b out_valid=%b busy=%b want 1 0 0", err, out_valid, busy); end
    endtask

`ifdef CCIP_RD_WATCHDOG_EN
    task automatic test_watchdog();
        int last, dcyc;
        clear_logs();
        base_addr = 42'h900; num_lines = 16'd4;
        start = 1'b1; step(); start = 1'b0;
        repeat (6) step();
        drive_rsp(16'd0); step();
        drive_rsp(16'd1); step();
        last = cyc;
        drive_rsp(16'd3); step();
        rsp_valid = 1'b0;
        dcyc = -1;
        for (int i = 0; i < 40 && dcyc < 0; i++) begin
            if (done) begin
                dcyc = cyc;
                cmp++; if (err !== 1'b1) begin nfail++; $display("FAIL wd_err: got %b want 1", err); end
            end
            step();
        end
        cmp++; if (dcyc < last + 14 || dcyc > last + 20) begin nfail++;
            $display("FAIL wd_done: got cyc=%0d want about %0d", dcyc, last + 16); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; start_b = 1'b0; req_almfull = 1'b0; rsp_valid = 1'b0;
        base_addr = '0; num_lines = '0; rsp_mdata = '0; rsp_data = '0;
        test_reset();
        test_basic();
        test_out_of_order();
        test_backpressure();
        test_wrap();
        test_zero_lines();
        test_errors();
        test_reset_midjob();
`ifdef CCIP_RD_WATCHDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, nfail);
        $finish;
    end

endmodule

// File: doc/ccip_rd_requester.md
# ccip_rd_requester

AFU-initiated host-memory read engine on CCI-P channel 0: turns a start command (base cache-line address, line count) into a stream of c0 read requests and forwards the returned cache lines downstream, tagged with their line index. It is the initiator counterpart of the AFU's MMIO responder: there the host requests and the AFU answers; here the AFU requests and the host answers. It sits between the MMIO control registers (which drive `start`) and the AFU's data path, alongside the CCI-P Tx/Rx shells.

## Interface
- `MAX_OUT`, 32: maximum outstanding read requests, range 1..1024.
- `WD_CYCLES`, 4096: watchdog limit in cycles; used only with the watchdog macro.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle command strobe; ignored while `busy`=1.
- `base_addr` in 42: first cache-line address; sampled on an accepted `start`.
- `num_lines` in 16: number of lines to read; sampled on an accepted `start`.
- `busy` out 1: high from an accepted `start` until the cycle `done` pulses.
- `done` out 1: one-cycle pulse when all lines have been received.
- `err` out 1: sticky error flag; cleared by an accepted `start`.
- `req_valid` out 1: c0 read request valid, registered.
- `req_addr` out 42: request cache-line address.
- `req_mdata` out 16: request tag, equal to the line index.
- `req_almfull` in 1: c0 Tx almost-full from the shell.
- `rsp_valid` in 1: c0 read response valid; cannot be stalled.
- `rsp_mdata` in 16: tag returned with the response.
- `rsp_data` in 512: returned cache line.
- `out_valid` out 1: forwarded line valid; there is no ready, so the consumer must accept every cycle.
- `out_idx` out 16: line index of `out_data`.
- `out_data` out 512: forwarded line.

## Operation
- FSM states:
  - IDLE: an accepted `start` goes to ISSUE, or to FINISH if `num_lines`=0.
  - ISSUE: goes to DRAIN once `issued`==`num_lines`.
  - DRAIN: goes to FINISH once `received`==`num_lines`.
  - FINISH: pulses `done`, clears `busy`, returns to IDLE.
- Counters, all 16-bit: `issued`, `received`, `outstanding` (0..MAX_OUT).
- Issue rule, checked every cycle in ISSUE: issue a request if `req_almfull`=0, `outstanding`<MAX_OUT and `issued`<`num_lines`. At most one request per cycle.
- Request fields:
  - `req_addr` = `base_addr` + `issued`, modulo 2^42 (wraps silently).
  - `req_mdata` = `issued`.
- Response handling: a response is valid if `busy`=1 and `rsp_mdata` < `num_lines`.
  - Valid response: forward it, increment `received`, decrement `outstanding`.
  - Otherwise: set `err`, drop the data, leave the counters unchanged.
- Responses may arrive in any order. The block does no reordering and no duplicate detection; `out_idx` identifies each line.
- Simultaneous issue and valid response in one cycle: `outstanding` is unchanged.
- Reset (including mid-operation): all state and outputs go to 0 and the FSM goes to IDLE. Responses arriving after reset set `err`.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `req_valid`=0, `req_addr`=0, `req_mdata`=0, `out_valid`=0, `out_idx`=0, `out_data`=0.
- An accepted `start` at cycle T: `busy`=1 at T+1; the earliest `req_valid` is at T+2.
- `req_almfull` sampled high at cycle T: no `req_valid` at T+1.
- Throughput: one request per cycle while the issue conditions hold.
- Response latency: `rsp_valid` at T gives `out_valid` at T+1. The forwarding path is fully pipelined, one line per cycle.
- Last valid response at T: `done`=1 and `busy`=0 at T+2.
- `num_lines`=0: `start` at T gives `done` at T+2, with no requests issued.

## Configuration
- `CCIP_RD_WATCHDOG_EN` defined:
  - A cycle counter resets on every valid response and on an accepted `start`, and counts while `outstanding`>0.
  - When it reaches `WD_CYCLES`, the block sets `err`, forces FINISH (so `done` pulses) and zeroes the counters.
- `CCIP_RD_WATCHDOG_EN` undefined: no watchdog logic; a lost response leaves `busy`=1 until reset.

## Test plan
- Basic read: `base_addr`=0x100, `num_lines`=4, host responds in order after 5 cycles. Required: requests at 0x100..0x103 with mdata 0..3; `out_idx` 0..3 with matching data; `done` once; `err`=0.
- Out-of-order responses: 8 lines returned in tag order 7,0,5,1,6,2,4,3. Required: 8 `out_valid` cycles with `out_idx` in that same order; `done` 2 cycles after tag 3 is returned.
- Backpressure: MAX_OUT=2, 6 lines, no responses for 20 cycles. Required: exactly 2 requests issued. Then hold `req_almfull`=1 while responding. Required: no new requests until `req_almfull` returns to 0.
- Boundary: `base_addr`=2^42-1, 2 lines. Required: `req_addr` = 2^42-1, then 0. Separately, `num_lines`=0. Required: `done` at T+2, no `req_valid`.
- Errors: response with tag 9 during a 4-line job, and a response while IDLE. Required: `err`=1 in each case, no `out_valid`; `err` clears on the next `start`.
- Reset and watchdog: assert `rst_n`=0 mid-job. Required: all outputs 0 and `busy`=0. With the watchdog macro defined and `WD_CYCLES`=16, drop one response. Required: `err`=1 and `done` pulses 16 cycles after the last valid response.
